// File: rtl/mem_responder_if.sv
// Processor bus and transmit stream bundle for mem_responder.
// Master is the processor/consumer side, slave is the responder.
interface mem_responder_if;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic [31:0] out_port;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output adr,
    output writedata,
    output memwrite,
    output tx_ready,
    input  readdata,
    input  out_port,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  adr,
    input  writedata,
    input  memwrite,
    input  tx_ready,
    output readdata,
    output out_port,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/mem_responder.sv
// Word RAM plus MMIO block: cycle counter, output port,
// and a transmit FIFO drained over a valid/ready stream.
module mem_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  mem_responder_if.slave  bus
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  localparam logic [1:0] OFF_CYC = 2'd0;
  localparam logic [1:0] OFF_OUT = 2'd1;
  localparam logic [1:0] OFF_TX  = 2'd2;
  localparam logic [1:0] OFF_ST  = 2'd3;

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] fifo [FIFO_DEPTH];

  logic [31:0]   cycles;
  logic [31:0]   outreg;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic          sel_ram;
  logic          sel_mmio;
  logic [1:0]    off;
  logic [AW-1:0] ram_idx;
  logic          unused_adr;

  logic wr_ram;
  logic wr_cyc;
  logic wr_out;
  logic wr_tx;
  logic clr_ovf;

  logic empty;
  logic full;
  logic pop;
  logic push_ok;
  logic push_drop;

  logic [31:0] head;
  logic [31:0] status;
  logic [31:0] rd;

  // Address decode; byte offset bits never matter.
  assign sel_ram    = bus.adr[31:28] != 4'hF;
  assign sel_mmio   = bus.adr[31:4] == 28'hFFFF000;
  assign off        = bus.adr[3:2];
  assign ram_idx    = bus.adr[AW+1:2];
  assign unused_adr = ^bus.adr[1:0];

  assign wr_ram  = bus.memwrite & sel_ram;
  assign wr_cyc  = bus.memwrite & sel_mmio & (off == OFF_CYC);
  assign wr_out  = bus.memwrite & sel_mmio & (off == OFF_OUT);
  assign wr_tx   = bus.memwrite & sel_mmio & (off == OFF_TX);
  assign clr_ovf = bus.memwrite & sel_mmio & (off == OFF_ST)
                 & bus.writedata[10];

  // A pop frees a slot in the same cycle, so a full
  // FIFO still accepts a push while it is draining.
  assign empty     = count == '0;
  assign full      = count == DEPTH;
  assign pop       = ~empty & bus.tx_ready;
  assign push_ok   = wr_tx & (~full | pop);
  assign push_drop = wr_tx & full & ~pop;

  // RAM store; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram[ram_idx] <= bus.writedata;
    end
  end

  // FIFO storage; stale slots are masked by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo[wptr] <= bus.writedata;
    end
  end

  // Free-running cycle counter, loadable from the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles <= '0;
    end else if (wr_cyc) begin
      cycles <= bus.writedata;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  // General-purpose output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outreg <= '0;
    end else if (wr_out) begin
      outreg <= bus.writedata;
    end
  end

  // FIFO pointers wrap naturally at the pointer width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
    end
  end

  // Occupancy tracks push/pop independently of pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a new drop beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (push_drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

  assign head   = empty ? 32'h0 : fifo[rptr];
  assign status = {21'h0, ovf, full, empty, 8'(count)};

  // Read mux sees only address and stored state.
  always_comb begin
    rd = 32'h0;
    unique case (1'b1)
      sel_ram: rd = ram[ram_idx];
      sel_mmio: begin
        unique case (off)
          OFF_CYC: rd = cycles;
          OFF_OUT: rd = outreg;
          OFF_TX:  rd = head;
          OFF_ST:  rd = status;
          default: rd = 32'h0;
        endcase
      end
      default: rd = 32'h0;
    endcase
  end

  assign bus.readdata = rd;
  assign bus.out_port = outreg;
  assign bus.tx_data  = head;
  assign bus.tx_valid = ~empty;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a queue-based
// reference model compared on every falling edge.
module tb_mem_responder;

  localparam int RAM_WORDS = 64;
  localparam int DEPTH     = 4;

  logic clk = 1'b0;
  logic reset;

  mem_responder_if bus ();

  mem_responder #(
    .RAM_WORDS (RAM_WORDS),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ram [int];
  logic [31:0] m_q [$];
  logic [31:0] m_cyc = 32'h0;
  logic [31:0] m_out = 32'h0;
  bit          m_ovf = 1'b0;
  bit          m_mmio;
  bit          m_pop;
  logic [1:0]  m_off;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % RAM_WORDS);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a,
                                         output bit known);
    int n;
    known = 1'b1;
    n = m_q.size();
    if (a[31:28] != 4'hF) begin
      known = m_ram.exists(widx(a));
      return known ? m_ram[widx(a)] : 32'h0;
    end
    if (a[31:4] != 28'hFFFF000) return 32'h0;
    case (a[3:2])
      2'd0:    return m_cyc;
      2'd1:    return m_out;
      2'd2:    return n != 0 ? m_q[0] : 32'h0;
      default: return {21'h0, m_ovf, n == DEPTH, n == 0, 8'(n)};
    endcase
  endfunction

  // Reference model: state moves on each rising edge.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_cyc = 32'h0;
      m_out = 32'h0;
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      m_mmio = bus.adr[31:4] == 28'hFFFF000;
      m_off  = bus.adr[3:2];
      m_pop  = m_q.size() != 0 && bus.tx_ready;
      if (bus.memwrite && m_mmio && m_off == 2'd0) m_cyc = bus.writedata;
      else m_cyc = m_cyc + 32'd1;
      if (bus.memwrite && m_mmio && m_off == 2'd1) m_out = bus.writedata;
      if (bus.memwrite && m_mmio && m_off == 2'd3 && bus.writedata[10])
        m_ovf = 1'b0;
      if (m_pop) void'(m_q.pop_front());
      if (bus.memwrite && m_mmio && m_off == 2'd2) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus.writedata);
        else m_ovf = 1'b1;
      end
      if (bus.memwrite && bus.adr[31:28] != 4'hF)
        m_ram[widx(bus.adr)] = bus.writedata;
    end
  end

  // Compare all outputs against the model each falling edge.
  initial forever begin
    logic [31:0] e;
    bit k;
    @(negedge clk);
    e = m_read(bus.adr, k);
    if (k) chk("cmp_readdata", bus.readdata, e);
    chk("cmp_tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
    chk("cmp_tx_data", bus.tx_data, m_q.size() != 0 ? m_q[0] : 32'h0);
    chk("cmp_out_port", bus.out_port, m_out);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.adr = a;
    bus.writedata = d;
    bus.memwrite = 1'b1;
    tick(1);
    bus.memwrite = 1'b0;
  endtask

  task automatic peek(input string name,
                      input logic [31:0] a,
                      input logic [31:0] exp);
    bus.adr = a;
    #1;
    chk(name, bus.readdata, exp);
  endtask

  initial begin
    reset = 1'b1;
    bus.adr = 32'h0;
    bus.writedata = 32'h0;
    bus.memwrite = 1'b0;
    bus.tx_ready = 1'b0;
    tick(2);
    chk("rst_out_port", bus.out_port, 32'h0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst_tx_data", bus.tx_data, 32'h0);
    peek("rst_status", 32'hFFFF000C, 32'h100);
    peek("rst_cycles", 32'hFFFF0000, 32'h0);

    reset = 1'b0;
    tick(10);
    peek("cyc_10", 32'hFFFF0000, 32'd10);
    wr(32'hFFFF0000, 32'hFFFFFFFE);
    peek("cyc_load", 32'hFFFF0000, 32'hFFFFFFFE);
    tick(1);
    peek("cyc_max", 32'hFFFF0000, 32'hFFFFFFFF);
    tick(1);
    peek("cyc_wrap", 32'hFFFF0000, 32'h0);

    wr(32'h00000010, 32'hDEADBEEF);
    peek("ram_rd", 32'h00000010, 32'hDEADBEEF);
    peek("ram_alias", 32'h00000110, 32'hDEADBEEF);
    peek("ram_byteoff", 32'h00000013, 32'hDEADBEEF);
    bus.adr = 32'h00000010;
    bus.writedata = 32'h11111111;
    bus.memwrite = 1'b1;
    #1;
    chk("rdw_old", bus.readdata, 32'hDEADBEEF);
    tick(1);
    bus.memwrite = 1'b0;
    #1;
    chk("rdw_new", bus.readdata, 32'h11111111);
    wr(32'h00000000, 32'hAAAA5555);

    for (int i = 1; i <= 5; i++) wr(32'hFFFF0008, 32'(i));
    peek("fifo_full_ovf", 32'hFFFF000C, 32'h604);
    chk("fifo_head", bus.tx_data, 32'd1);
    peek("fifo_peek", 32'hFFFF000A, 32'd1);
    wr(32'hFFFF000C, 32'h400);
    peek("ovf_clear", 32'hFFFF000C, 32'h204);

    bus.tx_ready = 1'b1;
    wr(32'hFFFF0008, 32'd9);
    bus.tx_ready = 1'b0;
    peek("full_pushpop", 32'hFFFF000C, 32'h204);
    bus.tx_ready = 1'b1;
    foreach (m_q[i]) begin end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_seq [4];
      exp_seq = '{32'd2, 32'd3, 32'd4, 32'd9};
      #1;
      chk("drain", bus.tx_data, exp_seq[i]);
      tick(1);
    end
    chk("drained_valid", 32'(bus.tx_valid), 32'h0);
    tick(1);
    bus.tx_ready = 1'b0;
    peek("drained_status", 32'hFFFF000C, 32'h100);

    wr(32'hFFFF0004, 32'h5A);
    chk("outport", bus.out_port, 32'h5A);
    wr(32'hFFFF0008, 32'd7);
    chk("push7_valid", 32'(bus.tx_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_out_port", bus.out_port, 32'h0);
    chk("arst_tx_valid", 32'(bus.tx_valid), 32'h0);
    chk("arst_tx_data", bus.tx_data, 32'h0);
    tick(1);
    reset = 1'b0;
    peek("post_rst_status", 32'hFFFF000C, 32'h100);
    peek("post_rst_cyc0", 32'hFFFF0000, 32'h0);
    tick(1);
    peek("post_rst_cyc1", 32'hFFFF0000, 32'h1);
    peek("ram_kept", 32'h00000010, 32'h11111111);

    peek("unmapped_rd", 32'hF0000000, 32'h0);
    wr(32'hF0000000, 32'h1234);
    peek("unmapped_rd2", 32'hF0000000, 32'h0);
    peek("unmapped_ram0", 32'h00000000, 32'hAAAA5555);
    peek("unmapped_ram4", 32'h00000010, 32'h11111111);
    peek("unmapped_status", 32'hFFFF000C, 32'h100);
    chk("unmapped_out", bus.out_port, 32'h0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 64: number of 32-bit words in the RAM region; power of two.
REQ-002 Parameter FIFO_DEPTH, default 4: number of entries in the transmit FIFO; power of two.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 adr  input  32  byte address from the processor.
REQ-006 writedata  input  32  store data from the processor.
REQ-007 memwrite  input  1  store strobe; one write per cycle while high.
REQ-008 readdata  output  32  combinational read data for the current adr.
REQ-009 out_port  output  32  registered general-purpose output port.
REQ-010 tx_data  output  32  FIFO head word.
REQ-011 tx_valid  output  1  FIFO non-empty.
REQ-012 tx_ready  input  1  consumer accepts the head word this cycle.

Function
REQ-013 Region decode: adr[31:28]!=4'hF selects RAM; adr[31:4]==28'hFFFF000 selects MMIO; any other address reads 32'h0 and ignores writes.
REQ-014 RAM: word index = adr[log2(RAM_WORDS)+1:2]; adr[1:0] and upper bits are ignored, so addresses alias.
REQ-015 RAM read is combinational, same cycle as adr; write of the full 32-bit word at the clk edge when memwrite=1.
REQ-016 MMIO 0xFFFF0000 CYCLES: 32-bit counter, +1 every cycle, wraps from FFFFFFFF to 0; a write loads writedata, so the next cycle reads writedata and increments from there.
REQ-017 MMIO 0xFFFF0004 OUTPORT: read/write register driving out_port; a write takes effect at the next edge.
REQ-018 MMIO 0xFFFF0008 TXDATA: a write pushes writedata; a read returns the head word (peek, no pop), or 0 when empty.
REQ-019 MMIO 0xFFFF000C STATUS read: [7:0]=count, [8]=empty, [9]=full, [10]=overflow, other bits 0.
REQ-020 STATUS write: writedata[10]=1 clears overflow; the other bits are ignored.
REQ-021 MMIO offsets use adr[3:2]; adr[1:0] are ignored.
REQ-022 Pop: tx_valid & tx_ready at the edge removes the head word.
REQ-023 tx_valid = (count!=0).
REQ-024 tx_data = head word, combinational from FIFO storage; 0 when empty.
REQ-025 Push while not full: accepted; count +1 unless a pop occurs in the same cycle.
REQ-026 Push while full with no pop: word dropped, FIFO unchanged, overflow set.
REQ-027 Push while full with a pop in the same cycle: push accepted, count stays FIFO_DEPTH, overflow unchanged.
REQ-028 Push and pop in the same cycle while non-empty: count unchanged, order preserved.
REQ-029 Pop while empty: impossible by REQ-023; FIFO state does not change.
REQ-030 Overflow is sticky; if an overflow event and a clear occur in the same cycle, set wins.
REQ-031 Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-032 count is a separate register, 0..FIFO_DEPTH.
REQ-033 readdata depends only on adr and current state, never on memwrite or writedata.
REQ-034 Read-during-write to the same location returns the old value that cycle and the new value from the next cycle.

Reset
REQ-035 While reset=1: CYCLES=0, out_port=0, FIFO pointers=0, count=0, overflow=0, tx_valid=0, tx_data=0.
REQ-036 RAM contents are not reset and are retained across reset.
REQ-037 Reset asserted mid-transfer discards all FIFO contents immediately; no pop is reported.
REQ-038 First increment of CYCLES occurs at the first rising edge after reset deasserts.

Verification
REQ-039 Write 0xDEADBEEF to adr 0x00000010, then read 0x00000010 and 0x00000110 (RAM_WORDS=64) -> both return 0xDEADBEEF; read 0x00000013 -> 0xDEADBEEF.
REQ-040 Release reset, wait 10 cycles, read 0xFFFF0000 -> 10; write 0xFFFFFFFE, read on the next two cycles -> 0xFFFFFFFE, 0xFFFFFFFF, then 0x0 (wrap).
REQ-041 tx_ready=0; push 1,2,3,4,5 -> STATUS=0x200|4 (full, count 4) plus bit 10 set; tx_data=1; write STATUS 0x400 -> overflow=0.
REQ-042 Full FIFO, tx_ready=1 and push 9 in the same cycle -> count stays 4, overflow stays 0; drain order 2,3,4,9 (after 1 pops); then tx_valid=0 and STATUS=0x100.
REQ-043 Write OUTPORT 0x5A, push 7, assert reset for one cycle -> out_port=0, tx_valid=0, STATUS=0x100, CYCLES restarts at 0, earlier RAM word still reads back intact.
REQ-044 Read 0xF0000000 -> 0; write 0x1234 there -> no RAM, MMIO or FIFO change.
